// File: rtl/and_or_not_if.sv
// Handshake bundle for the and_or_not gate cell.
// Optional coverage signals exist only when AON_COVERAGE_EN is defined.
interface and_or_not_if;
   logic       in_valid;
   logic       a;
   logic       b;
   logic       c;
   logic       out_valid;
   logic       d;
   logic       e;
`ifdef AON_COVERAGE_EN
   logic       cov_clr;
   logic [7:0] cov_mask;
   logic       all_cov;

   modport master (
      output in_valid, a, b, c, cov_clr,
      input  out_valid, d, e, cov_mask, all_cov
   );
   modport slave (
      input  in_valid, a, b, c, cov_clr,
      output out_valid, d, e, cov_mask, all_cov
   );
`else
   modport master (
      output in_valid, a, b, c,
      input  out_valid, d, e
   );
   modport slave (
      input  in_valid, a, b, c,
      output out_valid, d, e
   );
`endif
endinterface

// File: rtl/and_or_not.sv
// Registered three-input gate cell: d = (a & b) | ~c, e = ~c.
// The combinational core feeds a PIPE_STAGES-deep valid-qualified pipeline.
// Define AON_COVERAGE_EN to add the input-combination coverage tracker
// (cov_clr / cov_mask / all_cov on the interface).
module and_or_not #(
   parameter int unsigned PIPE_STAGES = 1
) (
   input logic         clk,
   input logic         rst,
   and_or_not_if.slave bus
);

   if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
      $error("and_or_not: PIPE_STAGES must be in 1..4");
   end

   logic w1;
   logic e_c;
   logic d_c;

   logic [PIPE_STAGES-1:0] valid_q, valid_d;
   logic [PIPE_STAGES-1:0] d_q, d_d;
   logic [PIPE_STAGES-1:0] e_q, e_d;

   // Combinational gate core.
   always_comb begin
      w1  = bus.a & bus.b;
      e_c = ~bus.c;
      d_c = w1 | e_c;
   end

   // Pipeline next state; data is zeroed at entry on bubbles so d/e read 0 whenever invalid.
   always_comb begin
      valid_d    = valid_q;
      d_d        = d_q;
      e_d        = e_q;
      valid_d[0] = bus.in_valid;
      d_d[0]     = bus.in_valid & d_c;
      e_d[0]     = bus.in_valid & e_c;
      for (int i = 1; i < PIPE_STAGES; i++) begin
         valid_d[i] = valid_q[i-1];
         d_d[i]     = d_q[i-1];
         e_d[i]     = e_q[i-1];
      end
   end

   // Pipeline registers with synchronous reset that flushes in-flight samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         d_q     <= '0;
         e_q     <= '0;
      end else begin
         valid_q <= valid_d;
         d_q     <= d_d;
         e_q     <= e_d;
      end
   end

   assign bus.out_valid = valid_q[PIPE_STAGES-1];
   assign bus.d         = d_q[PIPE_STAGES-1];
   assign bus.e         = e_q[PIPE_STAGES-1];

`ifdef AON_COVERAGE_EN
   logic [7:0] cov_mask_q, cov_mask_d;
   logic [2:0] cov_idx;

   // Coverage next state: mark accepted {a,b,c}; clear takes priority over marking.
   always_comb begin
      cov_idx    = {bus.a, bus.b, bus.c};
      cov_mask_d = cov_mask_q;
      if (bus.in_valid) begin
         cov_mask_d[cov_idx] = 1'b1;
      end
      if (bus.cov_clr) begin
         cov_mask_d = '0;
      end
   end

   // Coverage register; reset beats both clear and marking.
   always_ff @(posedge clk) begin
      if (rst) begin
         cov_mask_q <= '0;
      end else begin
         cov_mask_q <= cov_mask_d;
      end
   end

   assign bus.cov_mask = cov_mask_q;
   assign bus.all_cov  = &cov_mask_q;
`endif

endmodule

// File: tb/tb_and_or_not.sv
// Directed bench for and_or_not: two instances (PIPE_STAGES = 1 and 4) driven in lockstep.
// Expected {out_valid,d,e} come from a hand-written truth table delayed by a shift model.
module tb_and_or_not;

   logic clk;
   logic rst;

   int n_checks;
   int n_fail;

   logic [1:0] tt [8];   // {d,e} per {a,b,c}
   logic [2:0] m1;       // expected {out_valid,d,e} for PIPE_STAGES=1
   logic [2:0] m4 [4];   // expected stages for PIPE_STAGES=4
   logic       cov_clr_r;

   and_or_not_if if1 ();
   and_or_not_if if4 ();

   and_or_not #(.PIPE_STAGES(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   and_or_not #(.PIPE_STAGES(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Drive one cycle of stimulus, advance the model, then check both instances after the edge.
   task automatic step(input logic v, input logic [2:0] abc, input logic r, input string tag);
      logic [2:0] nxt;
      rst          = r;
      if1.in_valid = v;
      if4.in_valid = v;
      {if1.a, if1.b, if1.c} = abc;
      {if4.a, if4.b, if4.c} = abc;
`ifdef AON_COVERAGE_EN
      if1.cov_clr = cov_clr_r;
      if4.cov_clr = cov_clr_r;
`endif
      @(posedge clk);
      nxt = v ? {1'b1, tt[abc]} : 3'b000;
      if (r) begin
         m1 = 3'b000;
         for (int j = 0; j < 4; j++) m4[j] = 3'b000;
      end else begin
         m1 = nxt;
         for (int j = 3; j > 0; j--) m4[j] = m4[j-1];
         m4[0] = nxt;
      end
      #1;
      check({tag, "_p1"}, {5'b0, if1.out_valid, if1.d, if1.e}, {5'b0, m1});
      check({tag, "_p4"}, {5'b0, if4.out_valid, if4.d, if4.e}, {5'b0, m4[3]});
   endtask

   initial begin
      int lat;
      bit found;
      n_checks  = 0;
      n_fail    = 0;
      cov_clr_r = 1'b0;
      tt[0] = 2'b11; tt[1] = 2'b00; tt[2] = 2'b11; tt[3] = 2'b00;
      tt[4] = 2'b11; tt[5] = 2'b00; tt[6] = 2'b11; tt[7] = 2'b10;
      m1 = 3'b000;
      for (int j = 0; j < 4; j++) m4[j] = 3'b000;
      rst = 1'b1;

      // Reset held 3 cycles with a valid 000 input: outputs stay 0.
      for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b1, "rst");

      // Latency after release: count edges until the 4-stage instance shows out_valid.
      step(1'b1, 3'b000, 1'b0, "lat");
      check("lat_p1", {7'b0, if1.out_valid}, 8'd1);
      lat   = 1;
      found = 1'b0;
      while (!found && lat < 10) begin
         if (if4.out_valid) found = 1'b1;
         else begin
            step(1'b0, 3'b000, 1'b0, "lat");
            lat++;
         end
      end
      check("lat_p4", lat[7:0], 8'd4);
      for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b0, "flush");

      // Exhaustive sweep.
      for (int k = 0; k < 8; k++) step(1'b1, k[2:0], 1'b0, "sweep");
      for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b0, "drain");

      // Bubbles with abc=110.
      for (int i = 0; i < 8; i++) step((i % 2) == 0, 3'b110, 1'b0, "bub");
      for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b0, "drain");

      // Mid-stream reset at k=3 drops in-flight samples.
      for (int k = 0; k < 8; k++) step(1'b1, k[2:0], k == 3, "midrst");
      for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b0, "drain");

`ifdef AON_COVERAGE_EN
      cov_clr_r = 1'b1;
      step(1'b1, 3'b111, 1'b0, "cclr");
      cov_clr_r = 1'b0;
      check("cov_clr_win", if1.cov_mask, 8'h00);
      for (int k = 0; k < 7; k++) step(1'b1, k[2:0], 1'b0, "cov");
      check("cov_mask7f_p1", if1.cov_mask, 8'h7F);
      check("cov_mask7f_p4", if4.cov_mask, 8'h7F);
      check("all_cov0", {7'b0, if1.all_cov}, 8'd0);
      step(1'b1, 3'b111, 1'b0, "cov");
      check("cov_maskff", if1.cov_mask, 8'hFF);
      check("all_cov1", {7'b0, if1.all_cov}, 8'd1);
      cov_clr_r = 1'b1;
      step(1'b0, 3'b000, 1'b0, "cclr");
      cov_clr_r = 1'b0;
      check("cov_mask00", if1.cov_mask, 8'h00);
      check("cov_mask00_p4", if4.cov_mask, 8'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
